// File: rtl/serial_word_packer.sv
// Byte-stream to 32-bit word packer feeding the write side of the master-side async FIFO.
// Define PACKER_BIG_ENDIAN_EN to place the first byte of each word in bits [31:24].
module serial_word_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  Write_Request,
  input  logic [LEN_WIDTH-1:0]  i_RCC_BUFFER_LENGTH,
  input  logic [7:0]            i_serialized_input,
  input  logic                  i_serialized_input_valid,
  output logic                  o_serialized_input_ready,
  input  logic                  i_FIFO_full,
  output logic                  o_FIFO_wr_en,
  output logic [DATA_WIDTH-1:0] o_FIFO_din,
  output logic [1:0]            o_Byte_Counter,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_nxt;

  logic [LEN_WIDTH-1:0]  words_left;
  logic [LEN_WIDTH-1:0]  words_to_assemble;
  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_valid;
  logic                  overrun_q;

  logic                  start;
  logic                  ready;
  logic                  accept;
  logic                  word_done;
  logic                  fifo_wr;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] word_next;

  assign start = (state_q == S_IDLE) && Write_Request;

  // Lane 3 is only blocked when accepting it would need a hold register that cannot drain.
  assign ready = (state_q == S_COLLECT) && (words_to_assemble != '0) &&
                 !(hold_valid && (byte_cnt == 2'd3) && i_FIFO_full);

  assign fifo_wr   = hold_valid && !i_FIFO_full;
  assign accept    = i_serialized_input_valid && ready;
  assign word_done = accept && (byte_cnt == 2'd3);

`ifdef PACKER_BIG_ENDIAN_EN
  assign lane = ~byte_cnt;
`else
  assign lane = byte_cnt;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    word_next                = asm_q;
    word_next[lane*8 +: 8]   = i_serialized_input;
  end

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (Write_Request) begin
          state_nxt = (i_RCC_BUFFER_LENGTH != '0) ? S_COLLECT : S_DONE;
        end
      end
      S_COLLECT: begin
        if (fifo_wr && (words_left == LEN_WIDTH'(1))) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    o_serialized_input_ready = ready;
    o_FIFO_wr_en             = fifo_wr;
    o_FIFO_din               = hold_q;
    o_Byte_Counter           = byte_cnt;
    o_Busy                   = (state_q != S_IDLE);
    o_Done                   = (state_q == S_DONE);
    o_Overrun                = overrun_q;
  end

  // Datapath: assembly lanes, hold register and word counters.
  // NOTE: the data registers are reset too, so a reset discards partial and held words and o_FIFO_din reads 0.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      words_left        <= '0;
      words_to_assemble <= '0;
      byte_cnt          <= '0;
      asm_q             <= '0;
      hold_q            <= '0;
      hold_valid        <= 1'b0;
      overrun_q         <= 1'b0;
    end else if (start) begin
      words_left        <= i_RCC_BUFFER_LENGTH;
      words_to_assemble <= i_RCC_BUFFER_LENGTH;
      byte_cnt          <= '0;
      overrun_q         <= 1'b0;
    end else begin
      if (accept) begin
        asm_q    <= word_next;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (word_done) begin
        hold_q            <= word_next;
        words_to_assemble <= words_to_assemble - LEN_WIDTH'(1);
      end
      // A word completing in the same cycle as a drain refills the hold register.
      if (word_done) begin
        hold_valid <= 1'b1;
      end else if (fifo_wr) begin
        hold_valid <= 1'b0;
      end
      if (fifo_wr) begin
        words_left <= words_left - LEN_WIDTH'(1);
      end
      if ((state_q == S_COLLECT) && i_serialized_input_valid && !ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_packer.sv
// Self-checking bench for serial_word_packer: table-driven transfers plus stall, overrun,
// zero-length and mid-transfer reset sequences; FIFO writes are checked against a scoreboard.
module tb_serial_word_packer;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Write_Request = 1'b0;
  logic [5:0]  len = '0;
  logic [7:0]  din_byte = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        FIFO_full = 1'b0;
  logic        wr_en;
  logic [31:0] fifo_din;
  logic [1:0]  byte_counter;
  logic        busy;
  logic        done;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wr_cyc = -10;
  logic [31:0] exp_q[$];

  serial_word_packer #(.DATA_WIDTH(32), .LEN_WIDTH(6)) dut (
    .CLK                      (CLK),
    .RESETn                   (RESETn),
    .Write_Request            (Write_Request),
    .i_RCC_BUFFER_LENGTH      (len),
    .i_serialized_input       (din_byte),
    .i_serialized_input_valid (din_valid),
    .o_serialized_input_ready (din_ready),
    .i_FIFO_full              (FIFO_full),
    .o_FIFO_wr_en             (wr_en),
    .o_FIFO_din               (fifo_din),
    .o_Byte_Counter           (byte_counter),
    .o_Busy                   (busy),
    .o_Done                   (done),
    .o_Overrun                (overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  len;
    int          nbytes;
    logic [63:0] bytes;   // byte i in bits [8i+7:8i], arrival order
    logic [31:0] w0;      // little-endian expectations
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cfg(input logic [31:0] w);
`ifdef PACKER_BIG_ENDIAN_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Inputs change at negedge+1, outputs are sampled at negedge+2.
  always @(negedge CLK) cyc++;

  always @(negedge CLK) begin
    #2;
    if (wr_en === 1'b1) begin
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_fifo_write", fifo_din, 32'hxxxx_xxxx);
      end else begin
        check("fifo_word", fifo_din, exp_q.pop_front());
      end
    end
  end

  task automatic request(input logic [5:0] l);
    @(negedge CLK); #1;
    Write_Request = 1'b1;
    len           = l;
    @(negedge CLK); #1;
    Write_Request = 1'b0;
    #1;
    check("busy_after_req", 32'(busy), 32'd1);
    check("ready_after_req", 32'(din_ready), 32'(l != 0));
  endtask

  task automatic send_bytes(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      int  guard = 0;
      bit  sent  = 1'b0;
      while (!sent) begin
        @(negedge CLK); #1;
        if (din_ready) begin
          din_valid = 1'b1;
          din_byte  = bytes[8*i +: 8];
          sent      = 1'b1;
        end else begin
          din_valid = 1'b0;
          guard++;
          if (guard > 200) begin
            check("byte_accept_timeout", 32'(i), 32'(n));
            return;
          end
        end
      end
    end
    @(negedge CLK); #1;
    din_valid = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while (!done && guard < 100) begin
      @(negedge CLK); #2;
      guard++;
    end
    if (!done) begin
      check({name, "_done_timeout"}, 32'(done), 32'd1);
    end else begin
      check({name, "_done_after_last_write"}, 32'(cyc - last_wr_cyc), 32'd1);
      @(negedge CLK); #2;
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{len: 6'd2, nbytes: 8, bytes: 64'h8877665544332211, w0: 32'h44332211, w1: 32'h88776655};
    vecs[1] = '{len: 6'd1, nbytes: 4, bytes: 64'h00000000D4C3B2A1, w0: 32'hD4C3B2A1, w1: 32'h0};
    vecs[2] = '{len: 6'd2, nbytes: 8, bytes: 64'h04030201EFBEADDE, w0: 32'hEFBEADDE, w1: 32'h04030201};
    vecs[3] = '{len: 6'd1, nbytes: 4, bytes: 64'h0000000000FF00FF, w0: 32'h00FF00FF, w1: 32'h0};

    // Reset values.
    repeat (3) @(negedge CLK);
    #2;
    check("rst_ready", 32'(din_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_din", fifo_din, 32'd0);
    check("rst_byte_counter", 32'(byte_counter), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge CLK); #1;
    RESETn = 1'b1;
    #1;

    // Back-to-back byte streams with the FIFO never full.
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(cfg(vecs[v].w0));
      if (vecs[v].len == 6'd2) exp_q.push_back(cfg(vecs[v].w1));
      request(vecs[v].len);
      send_bytes(vecs[v].bytes, vecs[v].nbytes);
      wait_done("table");
      check("table_overrun", 32'(overrun), 32'd0);
    end

    // Length 1, FIFO full for 5 cycles after the word completes; a byte offered during the stall.
    FIFO_full = 1'b1;
    exp_q.push_back(cfg(32'h5A4B3C2D));
    request(6'd1);
    send_bytes(64'h000000005A4B3C2D, 4);
    for (int k = 0; k < 5; k++) begin
      check("stall_no_write", 32'(wr_en), 32'd0);
      check("stall_not_ready", 32'(din_ready), 32'd0);
      @(negedge CLK); #1;
      din_valid = (k == 1);
      din_byte  = 8'hEE;
      #1;
    end
    check("overrun_set", 32'(overrun), 32'd1);
    @(negedge CLK); #1;
    FIFO_full = 1'b0;
    #1;
    check("drain_write", 32'(wr_en), 32'd1);
    wait_done("stall1");
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Length 0: immediate done, overrun cleared, no write, idle byte ignored.
    request(6'd0);
    check("len0_done", 32'(done), 32'd1);
    check("req_clears_overrun", 32'(overrun), 32'd0);
    @(negedge CLK); #2;
    check("len0_done_pulse", 32'(done), 32'd0);
    check("len0_idle", 32'(busy), 32'd0);
    @(negedge CLK); #1;
    din_valid = 1'b1;
    din_byte  = 8'h77;
    @(negedge CLK); #1;
    din_valid = 1'b0;
    #1;
    check("idle_byte_no_overrun", 32'(overrun), 32'd0);

    // Length 2 with the FIFO full while the second word streams in.
    FIFO_full = 1'b1;
    exp_q.push_back(cfg(32'hC4C3C2C1));
    exp_q.push_back(cfg(32'hC8C7C6C5));
    request(6'd2);
    fork
      send_bytes(64'hC8C7C6C5C4C3C2C1, 8);
      begin
        repeat (10) @(negedge CLK);
        #2;
        check("lane3_blocked_ready", 32'(din_ready), 32'd0);
        check("lane3_blocked_counter", 32'(byte_counter), 32'd3);
        check("lane3_blocked_no_write", 32'(wr_en), 32'd0);
        @(negedge CLK);
        FIFO_full = 1'b0;
      end
    join
    wait_done("stall2");
    check("stall2_overrun", 32'(overrun), 32'd0);

    // Reset in the middle of the first word discards it.
    request(6'd1);
    send_bytes(64'h000000000000B2A1, 2);
    check("partial_counter", 32'(byte_counter), 32'd2);
    @(negedge CLK); #1;
    RESETn = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_counter", 32'(byte_counter), 32'd0);
    check("midrst_ready", 32'(din_ready), 32'd0);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_din", fifo_din, 32'd0);
    @(negedge CLK); #1;
    RESETn = 1'b1;
    #1;
    exp_q.push_back(cfg(32'hD4C3B2A1));
    request(6'd1);
    send_bytes(64'h00000000D4C3B2A1, 4);
    wait_done("after_reset");

    repeat (3) @(negedge CLK);
    #2;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_word_packer.md
# serial_word_packer

Write-direction counterpart to the FIFO reader/serializer. It accepts a byte stream with a valid/ready handshake and packs every four bytes into a 32-bit word, first byte in the least-significant lane. It pushes a programmed number of words into the write port of the master-side async FIFO. It sits in the slow clock domain, between the byte source and the FIFO write side, and lets the DMA path carry data back toward memory.

## Interface
Parameters:
- DATA_WIDTH, 32: FIFO word width; fixed to 4 bytes.
- LEN_WIDTH, 6: width of the word-count input.

Ports:
- CLK  in  1  block clock, rising edge.
- RESETn  in  1  asynchronous active-low reset.
- Write_Request  in  1  start pulse; samples i_RCC_BUFFER_LENGTH.
- i_RCC_BUFFER_LENGTH  in  LEN_WIDTH  number of words in the transfer.
- i_serialized_input  in  8  incoming byte.
- i_serialized_input_valid  in  1  byte valid.
- o_serialized_input_ready  out  1  block can accept a byte.
- i_FIFO_full  in  1  FIFO write-side full.
- o_FIFO_wr_en  out  1  FIFO write strobe.
- o_FIFO_din  out  32  word presented to the FIFO.
- o_Byte_Counter  out  2  byte lane the next accepted byte fills.
- o_Busy  out  1  transfer in progress.
- o_Done  out  1  one-cycle pulse after the last word is written.
- o_Overrun  out  1  sticky flag: a byte arrived while ready was low.

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE:
  - Write_Request=1 with length>0: load words_left=length and words_to_assemble=length; go to COLLECT.
  - Write_Request=1 with length=0: go to DONE.
  - Write_Request also clears o_Overrun.
- COLLECT:
  - A byte is accepted when valid && ready.
  - The byte is written into the assembly register lane o_Byte_Counter, bits [8k+7:8k]; o_Byte_Counter then increments mod 4.
  - When lane 3 is accepted, the completed word (with the new byte) moves into the hold register: hold_valid=1, words_to_assemble decrements, o_Byte_Counter wraps to 0.
- Hold drain:
  - o_FIFO_wr_en = hold_valid && ~i_FIFO_full. This path is combinational from registered hold_valid.
  - o_FIFO_din = hold register.
  - On a write, hold_valid clears and words_left decrements. If a new word completes in the same cycle, hold_valid stays 1 and the hold register takes the new word.
- o_serialized_input_ready = (state==COLLECT) && (words_to_assemble≠0) && !(hold_valid && o_Byte_Counter==3 && i_FIFO_full).
  - Lanes 0..2 keep accepting bytes while the hold register waits on a full FIFO.
- When words_left reaches 0 after a FIFO write, go to DONE.
- DONE: o_Done=1 for exactly one cycle, then go to IDLE.
- o_Busy=1 in COLLECT and DONE.
- Write_Request outside IDLE is ignored.
- valid=1 && ready=0:
  - in COLLECT: the byte is dropped and o_Overrun is set.
  - in IDLE: the byte is dropped silently, no flag.
- Reset, at any time: state=IDLE and all counters and flags go to 0. Partial bytes and any held word are discarded; no FIFO write occurs.

## Timing
- Reset values: o_serialized_input_ready=0, o_FIFO_wr_en=0, o_FIFO_din=0, o_Byte_Counter=0, o_Busy=0, o_Done=0, o_Overrun=0.
- Write_Request sampled at edge N: state=COLLECT and ready=1 from cycle N+1.
- Lane-3 byte accepted at edge M: hold_valid=1 in cycle M+1; o_FIFO_wr_en=1 in M+1 if the FIFO is not full.
- Last FIFO write at edge W: o_Done=1 in cycle W+1; back in IDLE, o_Busy=0, in cycle W+2.
- Sustained throughput: one byte per cycle, one word per 4 cycles, no bubbles while the FIFO is not full.
- Counters are LEN_WIDTH wide. Length is a plain word count with no wrap; the maximum is 63.

## Configuration
- PACKER_BIG_ENDIAN_EN
  - Defined: the first byte of each word lands in bits [31:24] and the fourth in bits [7:0]. o_Byte_Counter still counts 0..3 in arrival order.
  - Undefined: little-endian packing; first byte in bits [7:0].

## Test plan
- Length=2, bytes 11,22,33,44,55,66,77,88 at one per cycle, FIFO never full -> writes 0x44332211 then 0x88776655; o_Done one cycle after the second write; o_Overrun=0.
- Length=1, FIFO full held for 5 cycles after the word completes -> o_FIFO_wr_en=0 while full; the word is written in the first not-full cycle; o_Done follows one cycle later.
- Length=2, FIFO full, second-word bytes streaming -> three bytes accepted, ready drops on lane 3 until the FIFO drains; no byte lost; word order preserved.
- Length=0 -> o_Done pulses in the cycle after Write_Request; no FIFO write; ready stays 0.
- RESETn asserted after 2 bytes of word 1, then released, then Write_Request with length=1 and bytes A1,B2,C3,D4 -> no write before reset; exactly one write of 0xD4C3B2A1.
- With PACKER_BIG_ENDIAN_EN, length=1, bytes 11,22,33,44 -> writes 0x11223344; valid asserted during a stall sets o_Overrun=1 until the next Write_Request.
